// File: rtl/transpose_ram.sv
// transpose_ram
//   N x N lane RAM. Rows are written one per cycle under an active-low
//   per-lane mask. Reads return either a whole row or a transposed column,
//   one cycle after the request. A clear sequencer zeroes every row, one
//   row per cycle.
//
// Ports
//   i_clk        sole clock, posedge
//   i_rst        asynchronous active-high reset
//   i_wr_valid   write strobe
//   i_wr_addr    row to write
//   i_wr_be_n    active-low lane enables, bit i gates lane i
//   i_wr_data    write data, lane i = bits [i*LANE_W +: LANE_W]
//   i_rd_req     read request
//   i_rd_addr    row index (row read) or column index (column read)
//   i_rd_col     0 = row read, 1 = column read
//   o_rd_data    registered read data
//   o_rd_valid   high for one cycle, the cycle after an accepted request
//   i_clr_start  pulse that starts the clear sequence
//   o_busy       clear sequence in progress
module transpose_ram #(
  parameter int  N      = 8,
  parameter int  LANE_W = 8,
  localparam int AW     = $clog2(N),
  localparam int DW     = N * LANE_W
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_wr_valid,
  input  logic [AW-1:0] i_wr_addr,
  input  logic [N-1:0]  i_wr_be_n,
  input  logic [DW-1:0] i_wr_data,
  input  logic          i_rd_req,
  input  logic [AW-1:0] i_rd_addr,
  input  logic          i_rd_col,
  output logic [DW-1:0] o_rd_data,
  output logic          o_rd_valid,
  input  logic          i_clr_start,
  output logic          o_busy
);

  localparam logic [AW-1:0] CNT_ONE  = AW'(1);
  localparam logic [AW-1:0] CNT_LAST = AW'(N - 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [AW-1:0] r_clr_cnt;
  logic [AW-1:0] w_clr_cnt_nxt;
  logic          r_busy;
  logic          w_busy_nxt;
  logic          w_clr_we;
  logic          w_idle;
  logic          w_wr_en;
  logic          w_rd_en;
  logic [DW-1:0] w_col_data;
  logic [DW-1:0] w_rd_word;
  logic [DW-1:0] r_rd_data;
  logic          r_rd_valid;

  // Storage is deliberately not reset; only the clear sequencer zeroes it.
  logic [DW-1:0] r_mem [N];

  // While clearing, both ports are locked out. A clear request also drops a
  // write presented in the same cycle, but a read in that cycle still
  // completes with the pre-clear contents.
  assign w_idle  = (r_state == ST_IDLE);
  assign w_wr_en = i_wr_valid & w_idle & ~i_clr_start;
  assign w_rd_en = i_rd_req & w_idle;

  // Clear FSM state, counter and busy flag
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= ST_IDLE;
      r_clr_cnt <= '0;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_clr_cnt <= w_clr_cnt_nxt;
      r_busy    <= w_busy_nxt;
    end
  end

  // Clear FSM next state: one row per cycle, wrapping the counter back to 0
  always_comb begin
    w_state_nxt   = r_state;
    w_clr_cnt_nxt = r_clr_cnt;
    w_busy_nxt    = r_busy;
    w_clr_we      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_clr_start) begin
          w_state_nxt   = ST_CLEAR;
          w_clr_cnt_nxt = '0;
          w_busy_nxt    = 1'b1;
        end else begin
          w_state_nxt = ST_IDLE;
          w_busy_nxt  = 1'b0;
        end
      end
      ST_CLEAR: begin
        w_clr_we      = 1'b1;
        w_clr_cnt_nxt = r_clr_cnt + CNT_ONE;
        if (r_clr_cnt == CNT_LAST) begin
          w_state_nxt = ST_IDLE;
          w_busy_nxt  = 1'b0;
        end else begin
          w_state_nxt = ST_CLEAR;
          w_busy_nxt  = 1'b1;
        end
      end
      default: begin
        w_state_nxt   = ST_IDLE;
        w_clr_cnt_nxt = '0;
        w_busy_nxt    = 1'b0;
      end
    endcase
  end

  // Column gather: row r contributes its lane (N-1-c), placed in output
  // lane (N-1-r), so row 0 lands in the most significant lane.
  always_comb begin
    w_col_data = '0;
    for (int r = 0; r < N; r++) begin
      w_col_data[(N-1-r)*LANE_W +: LANE_W] =
        r_mem[r][(N-1-int'(i_rd_addr))*LANE_W +: LANE_W];
    end
  end

  // Read word select between row and column view
  always_comb begin
    w_rd_word = '0;
    if (i_rd_col) begin
      w_rd_word = w_col_data;
    end else begin
      w_rd_word = r_mem[i_rd_addr];
    end
  end

  // Array update: clear row or lane-masked row write
  always_ff @(posedge i_clk) begin
    if (w_clr_we) begin
      r_mem[r_clr_cnt] <= '0;
    end else if (w_wr_en) begin
      for (int i = 0; i < N; i++) begin
        if (!i_wr_be_n[i]) begin
          r_mem[i_wr_addr][i*LANE_W +: LANE_W] <= i_wr_data[i*LANE_W +: LANE_W];
        end
      end
    end
  end

  // Registered read port; the array is sampled before this edge's write,
  // which gives read-before-write on collisions.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= w_rd_en;
      if (w_rd_en) begin
        r_rd_data <= w_rd_word;
      end else begin
        r_rd_data <= r_rd_data;
      end
    end
  end

  assign o_rd_data  = r_rd_data;
  assign o_rd_valid = r_rd_valid;
  assign o_busy     = r_busy;

endmodule
